// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: shares the bidirectional 8-bit uio pad bus among NREQ
// requesters. It uses a round-robin grant with a burst cap for each ownership,
// and it forces a bus-idle turnaround (oe=00) before every new owner.
module uio_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;

  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [1:0]    TURN_LAST = 2'(TURN - 1);
  localparam logic [PW-1:0] REQ_LAST  = PW'(NREQ - 1);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            odir_q, odir_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [1:0]      tcnt_q, tcnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q;
  logic            rvalid_q;

  logic [PW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] own_oh;
  logic            others;
  logic            drive;

  // Round-robin search: first requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_p;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_p = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx   = (32'(ptr_q) + i) % NREQ;
      idx_p = PW'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
  end

  // One-hot of current owner and whether anyone else is waiting.
  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
    others          = |(req & ~own_oh);
  end

  // Next-state logic for the IDLE/TURN/OWN ownership sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    odir_d  = odir_q;
    beat_d  = beat_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = pick;
          odir_d  = dir[pick];
          beat_d  = '0;
          tcnt_d  = '0;
          state_d = (TURN > 0) ? S_TURN : S_OWN;
        end
      end
      S_TURN: begin
        if (tcnt_q == TURN_LAST) state_d = S_OWN;
        else                     tcnt_d  = tcnt_q + 2'd1;
      end
      S_OWN: begin
        if (!req[owner_q] || (beat_q == BEAT_LAST && others)) begin
          state_d = S_IDLE;
          ptr_d   = (owner_q == REQ_LAST) ? '0 : owner_q + 1'b1;
        end else if (beat_q != BEAT_LAST) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    gnt_d = '0;
    if (state_d == S_OWN) gnt_d[owner_d] = 1'b1;
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      odir_q  <= 1'b0;
      beat_q  <= '0;
      tcnt_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      odir_q  <= odir_d;
      beat_q  <= beat_d;
      tcnt_q  <= tcnt_d;
      gnt_q   <= gnt_d;
    end
  end

  // Capture the pad byte at the end of every read-grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (state_q == S_OWN && !odir_q) begin
      rdata_q  <= uio_in;
      rvalid_q <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  // The bus is driven only while a write owner holds the grant.
  always_comb begin
    drive   = (state_q == S_OWN) && odir_q;
    uio_oe  = drive ? '1 : '0;
    uio_out = drive ? wdata[32'(owner_q)*8 +: 8] : '0;
  end

  assign gnt    = gnt_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Testbench for uio_bus_arbiter. It runs directed scenarios and then randomized
// traffic, and compares the DUT against a behavioural ownership model.
module tb_uio_bus_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int TURN      = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, dir;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  rdata, uio_in, uio_out, uio_oe;
  logic        rvalid, busy;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: who owns the bus, cycles left before the grant, and
  // how many grant cycles have completed in this ownership.
  int         m_own, m_pre, m_held, m_ptr;
  bit         m_dir;
  logic [7:0] m_rdata;
  bit         m_rvalid;

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .TURN(TURN)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_pre = 0; m_held = 0; m_ptr = 0;
    m_dir = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
  endtask

  task automatic model_edge();
    bit granted;
    granted = (m_own >= 0) && (m_pre == 0);
    if (rst) begin
      model_reset();
      return;
    end
    if (granted && !m_dir) begin
      m_rdata  = uio_in;
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    if (m_own < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (m_own < 0 && req[k]) begin
          m_own  = k;
          m_dir  = dir[k];
          m_pre  = TURN;
          m_held = 0;
        end
      end
    end else if (m_pre > 0) begin
      m_pre--;
    end else begin
      m_held++;
      if (!req[m_own] || (m_held >= MAX_BURST && (req & ~(4'b0001 << m_own)) != 4'b0000)) begin
        m_ptr  = (m_own + 1) % NREQ;
        m_own  = -1;
        m_held = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit granted;
    logic [3:0] e_gnt;
    logic [7:0] e_out;
    granted = (m_own >= 0) && (m_pre == 0);
    e_gnt   = granted ? (4'b0001 << m_own) : 4'b0000;
    e_out   = (granted && m_dir) ? wdata[8*m_own +: 8] : 8'h00;
    chk("gnt", gnt, e_gnt);
    chk("busy", busy, m_own >= 0);
    chk("uio_oe", uio_oe, (granted && m_dir) ? 8'hFF : 8'h00);
    chk("uio_out", uio_out, e_out);
    chk("rvalid", rvalid, m_rvalid);
    chk("rdata", rdata, m_rdata);
    chk("gnt_onehot0", $countones(gnt) <= 1, 1);
    chk("oe_only_granted", (uio_oe != 8'h00) && (gnt == 4'b0000), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int gap;
    bit seen_w, got1;
    rst = 1'b1; req = '0; dir = '0; wdata = '0; uio_in = '0;
    model_reset();
    step();
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_out", uio_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    rst = 1'b0;

    // Scenario 1: single writer, turnaround, then release on req drop.
    req = 4'b0001; dir = 4'b0001; wdata[7:0] = 8'hA5;
    step();
    chk("t1_gnt_c1", gnt, 4'b0000);
    step();
    chk("t1_gnt_c2", gnt, 4'b0001);
    chk("t1_oe_c2", uio_oe, 8'hFF);
    chk("t1_out_c2", uio_out, 8'hA5);
    step(); step(); step();
    req = 4'b0000;
    step();
    chk("t1_gnt_c6", gnt, 4'b0000);
    chk("t1_oe_c6", uio_oe, 8'h00);
    step(); step();

    // Scenario 2: single reader.
    req = 4'b0010; dir = 4'b0000; uio_in = 8'h3C;
    step(); step();
    chk("t2_gnt_c2", gnt, 4'b0010);
    step();
    chk("t2_rdata_c3", rdata, 8'h3C);
    chk("t2_rvalid_c3", rvalid, 1'b1);
    req = 4'b0000;
    step();
    chk("t2_gnt_c4", gnt, 4'b0000);
    chk("t2_rvalid_c4", rvalid, 1'b1);
    step();
    chk("t2_rvalid_c5", rvalid, 1'b0);

    // Scenario 3: all four requesting, bursts of MAX_BURST with 2-cycle gaps.
    do_reset();
    req = 4'b1111; dir = 4'b1111; wdata = 32'h44332211;
    for (int c = 1; c <= 27; c++) begin
      logic [3:0] e;
      step();
      e = 4'b0000;
      if (c >= 2 && ((c - 2) % 6) < 4) e = 4'b0001 << (((c - 2) / 6) % 4);
      chk("t3_rr_gnt", gnt, e);
    end

    // Scenario 4: writer 0 hands over to reader 1 with a clean turnaround.
    do_reset();
    req = 4'b0011; dir = 4'b0001; wdata = 32'h000000C3;
    gap = 0; seen_w = 1'b0; got1 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("t4_no_overlap", (uio_oe == 8'hFF) && gnt[1], 1'b0);
      if (uio_oe == 8'hFF) seen_w = 1'b1;
      else if (seen_w && !gnt[1] && !got1) gap++;
      if (gnt[1] && !got1) begin
        got1 = 1'b1;
        chk("t4_gap", gap, 2);
      end
    end
    chk("t4_gnt1_seen", got1, 1'b1);

    // Scenario 5: lone requester keeps the bus past the burst cap.
    do_reset();
    req = 4'b0100; dir = 4'b0000;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c >= 2) chk("t5_hold", gnt, 4'b0100);
    end

    // Scenario 6: reset during owner 3 write, then ptr is back at 0.
    req = 4'b1000; dir = 4'b1000; wdata = 32'h5A000000;
    do_reset();
    for (int c = 1; c <= 4; c++) step();
    chk("t6_gnt_pre", gnt, 4'b1000);
    rst = 1'b1;
    step();
    chk("t6_gnt", gnt, 4'b0000);
    chk("t6_oe", uio_oe, 8'h00);
    chk("t6_rvalid", rvalid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    rst = 1'b0;
    req = 4'b1001; dir = 4'b1001;
    step(); step();
    chk("t6_rr_gnt", gnt, 4'b0001);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      dir    = 4'($urandom);
      wdata  = $urandom;
      uio_in = 8'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
